// File: rtl/key_cmd_sched_if.sv
// Key-to-command scheduler bus: debounced key events in, one command handshake out.
// The master side drives key events and cmd_ready; the slave side is the scheduler.
interface key_cmd_sched_if;
    logic [3:0] key_flag;
    logic [3:0] key_value;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [3:0] key_held;

    modport master (
        output key_flag,
        output key_value,
        output cmd_ready,
        input  cmd_valid,
        input  cmd_code,
        input  key_held
    );

    modport slave (
        input  key_flag,
        input  key_value,
        input  cmd_ready,
        output cmd_valid,
        output cmd_code,
        output key_held
    );
endinterface

// File: rtl/key_cmd_sched.sv
// Turns debounced key events into a round-robin command stream with valid/ready handshake.
// Define KEY_AUTO_REPEAT_EN to enable hold-to-repeat on left/right/down.
module key_cmd_sched #(
    parameter logic [31:0] RPT_DLY = 32'd25000000,
    parameter logic [31:0] RPT_PER = 32'd5000000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    key_cmd_sched_if.slave     bus_io
);

    typedef enum logic {StIdle, StIssue} state_e;

    state_e     state_q, state_d;
    logic       valid_q, valid_d;
    logic [1:0] code_q, code_d;
    logic [1:0] last_q, last_d;
    logic [3:0] held_q, held_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] press_ev, release_ev, rpt_set, grant_clr;
    logic [1:0] grant;

    assign press_ev   = bus_io.key_flag & ~bus_io.key_value;
    assign release_ev = bus_io.key_flag & bus_io.key_value;

`ifdef KEY_AUTO_REPEAT_EN
    logic [31:0] cnt_q [3];
    logic [31:0] cnt_d [3];

    always_comb begin
        rpt_set = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (press_ev[i]) begin
                cnt_d[i] = RPT_DLY;
            end else if (release_ev[i]) begin
                cnt_d[i] = '0;
            end else if (held_q[i] && (cnt_q[i] == 32'd1)) begin
                rpt_set[i] = 1'b1;
                cnt_d[i]   = RPT_PER;
            end else if (held_q[i] && (cnt_q[i] != 32'd0)) begin
                cnt_d[i] = cnt_q[i] - 32'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic unused_rpt;
    assign unused_rpt = ^{RPT_DLY, RPT_PER};
    assign rpt_set    = '0;
`endif

    // Round robin: nearest pending key after last_q wins, so scan offsets far-to-near.
    always_comb begin
        logic [1:0] idx;
        idx   = '0;
        grant = last_q + 2'd1;
        for (int k = 3; k >= 0; k--) begin
            idx = last_q + 2'd1 + 2'(k);
            if (pend_q[idx]) grant = idx;
        end
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        code_d    = code_q;
        last_d    = last_q;
        grant_clr = '0;
        unique case (state_q)
            StIdle: begin
                if (|pend_q) begin
                    state_d   = StIssue;
                    valid_d   = 1'b1;
                    code_d    = grant;
                    last_d    = grant;
                    grant_clr = 4'b0001 << grant;
                end
            end
            StIssue: begin
                if (bus_io.cmd_ready) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
        // A new request landing on the granted key in the same cycle survives the clear.
        pend_d = (pend_q & ~grant_clr) | press_ev | rpt_set;
        held_d = (held_q | press_ev) & ~release_ev;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            code_q  <= 2'd0;
            last_q  <= 2'd3;
            held_q  <= 4'd0;
            pend_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            last_q  <= last_d;
            held_q  <= held_d;
            pend_q  <= pend_d;
        end
    end

    assign bus_io.cmd_valid = valid_q;
    assign bus_io.cmd_code  = code_q;
    assign bus_io.key_held  = held_q;

endmodule

// File: tb/tb_key_cmd_sched.sv
// Self-checking bench for key_cmd_sched: directed scenarios plus random stimulus
// against an event-time reference model (repeat deadlines kept as absolute cycle numbers).
module tb_key_cmd_sched;

    localparam int RptDly = 10;
    localparam int RptPer = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_cmd_sched_if bus ();

    key_cmd_sched #(
        .RPT_DLY (32'(RptDly)),
        .RPT_PER (32'(RptPer))
    ) u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus_io    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int dut_xfers [4];

    // Reference model state
    int         m_cyc;
    int         m_nxt [4];
    logic [3:0] m_held;
    logic [3:0] m_pend;
    logic       m_valid;
    logic [1:0] m_code;
    logic [1:0] m_last;

    task automatic model_reset();
        m_cyc   = 0;
        m_held  = '0;
        m_pend  = '0;
        m_valid = 1'b0;
        m_code  = 2'd0;
        m_last  = 2'd3;
        for (int i = 0; i < 4; i++) begin
            m_nxt[i]     = 0;
            dut_xfers[i] = 0;
        end
    endtask

    task automatic model_step();
        logic [3:0] set;
        logic [1:0] g;
        logic       found;
        set = '0;
        m_cyc++;
        for (int i = 0; i < 4; i++) begin
            if (bus.key_flag[i] && !bus.key_value[i]) begin
                m_held[i] = 1'b1;
                set[i]    = 1'b1;
                m_nxt[i]  = m_cyc + RptDly;
            end else if (bus.key_flag[i] && bus.key_value[i]) begin
                m_held[i] = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
            end else if (i < 3 && m_held[i] && m_cyc == m_nxt[i]) begin
                set[i]   = 1'b1;
                m_nxt[i] = m_cyc + RptPer;
`endif
            end
        end
        if (!m_valid) begin
            found = 1'b0;
            g     = 2'd0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && m_pend[(m_last + k) % 4]) begin
                    found = 1'b1;
                    g     = 2'((m_last + k) % 4);
                end
            end
            if (found) begin
                m_valid   = 1'b1;
                m_code    = g;
                m_last    = g;
                m_pend[g] = 1'b0;
            end
        end else if (bus.cmd_ready) begin
            m_valid = 1'b0;
        end
        m_pend = m_pend | set;
    endtask

    task automatic tick();
        if (bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) dut_xfers[bus.cmd_code]++;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_keys(input logic [3:0] flag, input logic [3:0] val);
        bus.key_flag  = flag;
        bus.key_value = val;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.cmd_ready = 1'b0;
        set_keys(4'h0, 4'hF);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b want 0", bus.cmd_valid);
        end
        n_checks++;
        if (bus.cmd_code !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_code: got %0d want 0", bus.cmd_code);
        end
        n_checks++;
        if (bus.key_held !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_held: got %b want 0000", bus.key_held);
        end
    endtask

    task automatic test_all_four();
        logic       ev;
        logic [1:0] ec;
        do_reset();
        bus.cmd_ready = 1'b1;
        set_keys(4'hF, 4'h0);
        tick();
        set_keys(4'h0, 4'hF);
        n_checks++;
        if (bus.key_held !== 4'hF) begin
            n_errors++;
            $display("FAIL all4_held: got %b want 1111", bus.key_held);
        end
        for (int t = 1; t <= 8; t++) begin
            tick();
            ev = (t % 2 == 1);
            ec = 2'((t - 1) / 2);
            n_checks++;
            if (bus.cmd_valid !== ev) begin
                n_errors++;
                $display("FAIL all4_valid t=%0d: got %b want %b", t, bus.cmd_valid, ev);
            end
            if (ev) begin
                n_checks++;
                if (bus.cmd_code !== ec) begin
                    n_errors++;
                    $display("FAIL all4_code t=%0d: got %0d want %0d", t, bus.cmd_code, ec);
                end
            end
        end
        set_keys(4'hF, 4'hF);
        tick();
        set_keys(4'h0, 4'hF);
        n_checks++;
        if (bus.key_held !== 4'h0) begin
            n_errors++;
            $display("FAIL all4_release: got %b want 0000", bus.key_held);
        end
    endtask

`ifdef KEY_AUTO_REPEAT_EN
    task automatic test_auto_repeat();
        logic ev;
        do_reset();
        bus.cmd_ready = 1'b1;
        set_keys(4'h1, 4'h0);
        tick();
        n_checks++;
        if (bus.cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rpt_t0: got %b want 0", bus.cmd_valid);
        end
        for (int t = 1; t <= 40; t++) begin
            if (t == 28) set_keys(4'h1, 4'hF);
            else         set_keys(4'h0, 4'hF);
            tick();
            ev = (t == 1) || (t >= 11 && t <= 27 && (t - 11) % 4 == 0);
            n_checks++;
            if (bus.cmd_valid !== ev || (ev && bus.cmd_code !== 2'd0)) begin
                n_errors++;
                $display("FAIL rpt_cycle t=%0d: got v=%b c=%0d want v=%b c=0",
                         t, bus.cmd_valid, bus.cmd_code, ev);
            end
        end
        n_checks++;
        if (dut_xfers[0] != 6) begin
            n_errors++;
            $display("FAIL rpt_count: got %0d want 6", dut_xfers[0]);
        end
    endtask
`else
    task automatic test_no_repeat();
        do_reset();
        bus.cmd_ready = 1'b1;
        set_keys(4'h1, 4'h0);
        tick();
        set_keys(4'h0, 4'hF);
        for (int t = 0; t < 100; t++) tick();
        n_checks++;
        if (dut_xfers[0] != 1 || bus.cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL norpt_count: got %0d xfers v=%b want 1 v=0", dut_xfers[0], bus.cmd_valid);
        end
        set_keys(4'h1, 4'hF);
        tick();
        set_keys(4'h0, 4'hF);
    endtask
`endif

    task automatic test_stall();
        do_reset();
        set_keys(4'h8, 4'h0);
        tick();
        set_keys(4'h0, 4'hF);
        for (int t = 1; t <= 20; t++) begin
            tick();
            n_checks++;
            if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'd3) begin
                n_errors++;
                $display("FAIL stall_hold t=%0d: got v=%b c=%0d want v=1 c=3",
                         t, bus.cmd_valid, bus.cmd_code);
            end
        end
        bus.cmd_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL stall_drop: got %b want 0", bus.cmd_valid);
        end
        for (int t = 0; t < 10; t++) tick();
        n_checks++;
        if (dut_xfers[3] != 1) begin
            n_errors++;
            $display("FAIL stall_count: got %0d want 1", dut_xfers[3]);
        end
        set_keys(4'h8, 4'hF);
        tick();
        set_keys(4'h0, 4'hF);
    endtask

    task automatic test_double_press();
        do_reset();
        set_keys(4'h1, 4'h0);
        tick();
        set_keys(4'h1, 4'hF);
        tick();
        n_checks++;
        if (bus.cmd_valid !== 1'b1 || bus.cmd_code !== 2'd0) begin
            n_errors++;
            $display("FAIL dbl_first: got v=%b c=%0d want v=1 c=0", bus.cmd_valid, bus.cmd_code);
        end
        set_keys(4'h2, 4'h0);
        tick();
        set_keys(4'h2, 4'hF);
        tick();
        set_keys(4'h2, 4'h0);
        tick();
        set_keys(4'h2, 4'hF);
        tick();
        set_keys(4'h0, 4'hF);
        bus.cmd_ready = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        n_checks++;
        if (dut_xfers[1] != 1 || dut_xfers[0] != 1) begin
            n_errors++;
            $display("FAIL dbl_count: got k0=%0d k1=%0d want 1 1", dut_xfers[0], dut_xfers[1]);
        end
    endtask

    task automatic test_rotate_hold();
        do_reset();
        bus.cmd_ready = 1'b1;
        set_keys(4'h8, 4'h0);
        tick();
        set_keys(4'h0, 4'hF);
        for (int t = 0; t < 100; t++) tick();
        n_checks++;
        if (dut_xfers[3] != 1) begin
            n_errors++;
            $display("FAIL rot_hold: got %0d want 1", dut_xfers[3]);
        end
        set_keys(4'h8, 4'hF);
        tick();
        set_keys(4'h0, 4'hF);
    endtask

    task automatic test_reset_mid_issue();
        int total;
        do_reset();
        set_keys(4'h8, 4'h0);
        tick();
        set_keys(4'h0, 4'hF);
        tick();
        n_checks++;
        if (bus.cmd_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_issue: got %b want 1", bus.cmd_valid);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.cmd_valid !== 1'b0 || bus.key_held !== 4'h0) begin
            n_errors++;
            $display("FAIL rmid_async: got v=%b held=%b want v=0 held=0000",
                     bus.cmd_valid, bus.key_held);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        bus.cmd_ready = 1'b1;
        for (int t = 0; t < 20; t++) tick();
        total = dut_xfers[0] + dut_xfers[1] + dut_xfers[2] + dut_xfers[3];
        n_checks++;
        if (total != 0 || bus.cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_after: got %0d xfers v=%b want 0 v=0", total, bus.cmd_valid);
        end
    endtask

    task automatic test_random();
        logic [3:0] f;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) f[i] = ($urandom_range(0, 31) == 0);
            set_keys(f, 4'($urandom));
            bus.cmd_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (bus.cmd_valid !== m_valid || bus.cmd_code !== m_code || bus.key_held !== m_held) begin
                n_errors++;
                $display("FAIL rand c=%0d: got v=%b c=%0d h=%b want v=%b c=%0d h=%b",
                         c, bus.cmd_valid, bus.cmd_code, bus.key_held, m_valid, m_code, m_held);
            end
        end
        set_keys(4'h0, 4'hF);
    endtask

    initial begin
        bus.cmd_ready = 1'b0;
        set_keys(4'h0, 4'hF);
        model_reset();
        test_reset();
        test_all_four();
`ifdef KEY_AUTO_REPEAT_EN
        test_auto_repeat();
`else
        test_no_repeat();
`endif
        test_stall();
        test_double_press();
        test_rotate_hold();
        test_reset_mid_issue();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_cmd_sched.md
KEY_CMD_SCHED -- requirements
Module: key_cmd_sched

Interface
REQ-001 The block SHALL have parameter RPT_DLY, default 32'd25000000, hold cycles before the first auto-repeat (500 ms at 50 MHz).
REQ-002 The block SHALL have parameter RPT_PER, default 32'd5000000, cycles between subsequent auto-repeats (100 ms).
REQ-003 The block SHALL have port sys_clk, input, 1, 50 MHz system clock; the single clock, all logic on its rising edge.
REQ-004 The block SHALL have port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port key_flag, input, 4, per-key one-cycle debounce-done pulse; bit 0 left, 1 right, 2 down, 3 rotate.
REQ-006 The block SHALL have port key_value, input, 4, per-key debounced level; 0 = pressed, 1 = released; sampled only when the matching key_flag bit is 1.
REQ-007 The block SHALL have port cmd_ready, input, 1, game logic accepts a command.
REQ-008 The block SHALL have port cmd_valid, output, 1, command available.
REQ-009 The block SHALL have port cmd_code, output, 2, command: 0 left, 1 right, 2 down, 3 rotate.
REQ-010 The block SHALL have port key_held, output, 4, registered per-key pressed state.

Function
REQ-011 A press event for key i SHALL be key_flag[i]=1 with key_value[i]=0; a release event SHALL be key_flag[i]=1 with key_value[i]=1.
REQ-012 On a press event the block SHALL set held[i] and pending[i] and load repeat counter i with RPT_DLY.
REQ-013 On a release event the block SHALL clear held[i] and zero counter i; pending[i] SHALL NOT be cleared.
REQ-014 For keys 0-2 with held[i]=1, counter i SHALL decrement each cycle; on reaching 1 it SHALL set pending[i] and reload RPT_PER.
REQ-015 Key 3 (rotate) SHALL never auto-repeat; only press events set pending[3].
REQ-016 A pending set on a key whose pending bit is already 1 SHALL be absorbed; at most one outstanding command per key.
REQ-017 The FSM SHALL have two states: IDLE and ISSUE.
REQ-018 IDLE -> ISSUE SHALL occur when any pending bit is 1; the grant is selected round-robin, searching from (last_grant+1) mod 4 upward.
REQ-019 On entering ISSUE the FSM SHALL clear the granted pending bit, register cmd_code and assert cmd_valid; a pending bit set at cycle N SHALL give cmd_valid at N+1 when IDLE.
REQ-020 In ISSUE, cmd_valid and cmd_code SHALL be held stable until cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-021 After a transfer the FSM SHALL return to IDLE; cmd_valid SHALL be 0 for at least one cycle between commands.
REQ-022 If a set of pending[i] coincides with the clear of pending[i] by grant, the set SHALL win: the bit stays 1.
REQ-023 Simultaneous events on different keys in one cycle SHALL all be recorded.
REQ-024 last_grant SHALL update only on entry to ISSUE.
REQ-025 Counter arithmetic SHALL be 32-bit unsigned; a counter at 0 SHALL stay 0.

Reset
REQ-026 Asserting sys_rst_n=0 SHALL immediately force IDLE, cmd_valid=0, cmd_code=0, key_held=0, pending=0, all counters=0 and last_grant=3, so the first grant searches from key 0.
REQ-027 Reset during ISSUE SHALL discard the outstanding command without a transfer.

Configuration
REQ-028 With macro KEY_AUTO_REPEAT_EN defined, REQ-014 SHALL apply and the repeat counters SHALL be present.
REQ-029 Without KEY_AUTO_REPEAT_EN, the repeat counters SHALL be omitted, only press events SHALL set pending bits, and RPT_DLY and RPT_PER SHALL be ignored.

Verification
REQ-030 The bench SHALL cover: RPT_DLY=10, RPT_PER=4, left press at cycle 0, cmd_ready=1 -> cmd_code=0 valid at cycle 1, repeats near cycle 10 and every 4 cycles after, none after release.
REQ-031 The bench SHALL cover: presses of all four keys in the same cycle, cmd_ready=1 -> commands 0,1,2,3 in order, each separated by an idle cycle.
REQ-032 The bench SHALL cover: rotate press with cmd_ready=0 for 20 cycles -> cmd_valid=1 and cmd_code=3 stable throughout, single transfer when ready rises.
REQ-033 The bench SHALL cover: a second press of key 1 while pending[1] is already set -> exactly one command 1.
REQ-034 The bench SHALL cover: rotate held for 100 cycles -> exactly one command 3.
REQ-035 The bench SHALL cover: reset asserted mid-ISSUE -> cmd_valid=0 immediately and no further commands after release of reset; without KEY_AUTO_REPEAT_EN, a left press held for 100 cycles -> exactly one command 0.
